hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 179 +++++++++++++++++
 tb/tb_hazard_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use/RAW stalls, control-flow
// redirects, data-memory wait handling with a held redirect, and perf counters.
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            id_opcode,
  input  logic [6:0]            ex_opcode,
  input  logic [6:0]            mem_opcode,
  input  logic [6:0]            wb_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  output logic [1:0]            pc_sel,
  output logic                  hold_pc,
  output logic                  hold_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic                  hold_all,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel,
  output logic [PERF_W-1:0]     stall_count,
  output logic [PERF_W-1:0]     flush_count
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t     state_q, state_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_sel_q, pend_sel_d;

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LD, OP_LUI, OP_AUI, OP_JAL, OP_JALR: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_ST, OP_BR: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  // True when the ID instruction reads a source register equal to rd.
  function automatic logic id_reads(input logic [REG_ADDR_W-1:0] rd);
    return (uses_rs1(id_opcode) && id_rs1 == rd) || (uses_rs2(id_opcode) && id_rs2 == rd);
  endfunction

  logic       ex_prod, mem_prod, wb_prod;
  logic       load_use, raw, stall_req;
  logic [1:0] redirect_sel;

  assign ex_prod  = writes_rd(ex_opcode)  && ex_rd  != '0;
  assign mem_prod = writes_rd(mem_opcode) && mem_rd != '0;
  assign wb_prod  = writes_rd(wb_opcode)  && wb_rd  != '0;

  assign load_use  = ex_opcode == OP_LD && ex_rd != '0 && id_reads(ex_rd);
  assign raw       = FWD_EN == 0 && ((ex_prod  && id_reads(ex_rd)) ||
                                     (mem_prod && id_reads(mem_rd)) ||
                                     (wb_prod  && id_reads(wb_rd)));
  assign stall_req = load_use || raw;

  always_comb begin
    redirect_sel = 2'd0;
    case (ex_opcode)
      OP_JAL:  redirect_sel = 2'd1;
      OP_JALR: redirect_sel = 2'd2;
      OP_BR:   redirect_sel = branch_taken ? 2'd3 : 2'd0;
      default: redirect_sel = 2'd0;
    endcase
  end

  // MEM beats WB since it holds the younger value of the register.
  always_comb begin
    fwd_rs1_sel = 2'd0;
    fwd_rs2_sel = 2'd0;
    if (FWD_EN != 0) begin
      if (mem_prod && mem_rd == ex_rs1 && uses_rs1(ex_opcode))     fwd_rs1_sel = 2'd1;
      else if (wb_prod && wb_rd == ex_rs1 && uses_rs1(ex_opcode))  fwd_rs1_sel = 2'd2;
      if (mem_prod && mem_rd == ex_rs2 && uses_rs2(ex_opcode))     fwd_rs2_sel = 2'd1;
      else if (wb_prod && wb_rd == ex_rs2 && uses_rs2(ex_opcode))  fwd_rs2_sel = 2'd2;
    end
  end

  // Controls must act in the cycle the hazard is visible, so they are decoded
  // combinationally from the current state and stage contents.
  // NOTE: every output and next-state variable gets a default first so no latch is inferred.
  always_comb begin
    pc_sel       = 2'd0;
    hold_pc      = 1'b0;
    hold_ifid    = 1'b0;
    flush_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    hold_all     = 1'b0;
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_sel_d   = pend_sel_q;
    if (!rst) begin
      if (dmem_busy) begin
        hold_all  = 1'b1;
        hold_pc   = 1'b1;
        hold_ifid = 1'b1;
        if (state_q == RUN) begin
          state_d = MEM_WAIT;
          if (redirect_sel != 2'd0) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = redirect_sel;
          end
        end
      end else if (state_q == MEM_WAIT && pend_valid_q) begin
        state_d      = RUN;
        pc_sel       = pend_sel_q;
        flush_ifid   = 1'b1;
        bubble_idex  = 1'b1;
        pend_valid_d = 1'b0;
        pend_sel_d   = 2'd0;
      end else if (state_q == RUN && redirect_sel != 2'd0) begin
        pc_sel      = redirect_sel;
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else begin
        state_d = RUN;
        if (stall_req) begin
          hold_pc     = 1'b1;
          hold_ifid   = 1'b1;
          bubble_idex = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= 2'd0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      if (hold_pc && stall_count != '1)
        stall_count <= stall_count + PERF_W'(1);
      if (flush_ifid && flush_count != '1)
        flush_count <= flush_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a forwarding instance and a stall-only instance
// share stimulus; expectations are queued as each cycle is driven.
module tb_hazard_unit;
  localparam int AW = 5;
  localparam int PW = 16;
  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct {
    logic [6:0]    id_op, ex_op, mem_op, wb_op;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          taken, busy;
  } stim_t;

  typedef struct {
    logic [10:0]   ctl;
    logic [10:0]   ctl_alt;
    logic [PW-1:0] stall, flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0]    id_opcode, ex_opcode, mem_opcode, wb_opcode;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          branch_taken, dmem_busy;

  logic [1:0]    pc_sel_a, fwd1_a, fwd2_a, pc_sel_b, fwd1_b, fwd2_b;
  logic          hold_pc_a, hold_ifid_a, flush_ifid_a, bubble_idex_a, hold_all_a;
  logic          hold_pc_b, hold_ifid_b, flush_ifid_b, bubble_idex_b, hold_all_b;
  logic [PW-1:0] stall_a, flush_a, stall_b, flush_b;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(1), .PERF_W(PW)) u_fwd (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .ex_opcode(ex_opcode), .mem_opcode(mem_opcode), .wb_opcode(wb_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_sel(pc_sel_a), .hold_pc(hold_pc_a), .hold_ifid(hold_ifid_a), .flush_ifid(flush_ifid_a),
    .bubble_idex(bubble_idex_a), .hold_all(hold_all_a),
    .fwd_rs1_sel(fwd1_a), .fwd_rs2_sel(fwd2_a),
    .stall_count(stall_a), .flush_count(flush_a)
  );

  hazard_unit #(.REG_ADDR_W(AW), .FWD_EN(0), .PERF_W(PW)) u_stall (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .ex_opcode(ex_opcode), .mem_opcode(mem_opcode), .wb_opcode(wb_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_sel(pc_sel_b), .hold_pc(hold_pc_b), .hold_ifid(hold_ifid_b), .flush_ifid(flush_ifid_b),
    .bubble_idex(bubble_idex_b), .hold_all(hold_all_b),
    .fwd_rs1_sel(fwd1_b), .fwd_rs2_sel(fwd2_b),
    .stall_count(stall_b), .flush_count(flush_b)
  );

  // {pc_sel, hold_pc, hold_ifid, flush_ifid, bubble_idex, hold_all, fwd_rs1, fwd_rs2}
  function automatic logic [10:0] pack(int pc, int hp, int hi, int fl, int bu, int ha, int f1, int f2);
    return {2'(pc), 1'(hp), 1'(hi), 1'(fl), 1'(bu), 1'(ha), 2'(f1), 2'(f2)};
  endfunction

  function automatic logic [10:0] obs_a();
    return {pc_sel_a, hold_pc_a, hold_ifid_a, flush_ifid_a, bubble_idex_a, hold_all_a, fwd1_a, fwd2_a};
  endfunction

  function automatic logic [10:0] obs_b();
    return {pc_sel_b, hold_pc_b, hold_ifid_b, flush_ifid_b, bubble_idex_b, hold_all_b, fwd1_b, fwd2_b};
  endfunction

  function automatic stim_t st(logic [6:0] iop, int irs1, int irs2, logic [6:0] eop, int ers1,
                               int ers2, int erd, logic [6:0] mop, int mrd, logic [6:0] wop,
                               int wrd, int tk, int bz);
    stim_t s;
    s.id_op = iop;  s.id_rs1 = AW'(irs1); s.id_rs2 = AW'(irs2);
    s.ex_op = eop;  s.ex_rs1 = AW'(ers1); s.ex_rs2 = AW'(ers2); s.ex_rd = AW'(erd);
    s.mem_op = mop; s.mem_rd = AW'(mrd);  s.wb_op = wop; s.wb_rd = AW'(wrd);
    s.taken = 1'(tk); s.busy = 1'(bz);
    return s;
  endfunction

  function automatic exp_t ex(logic [10:0] c, int s, int f, logic [10:0] alt = '0);
    exp_t e;
    e.ctl = c; e.ctl_alt = alt; e.stall = PW'(s); e.flush = PW'(f);
    return e;
  endfunction

  task automatic apply(input stim_t s);
    id_opcode = s.id_op;   id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    ex_opcode = s.ex_op;   ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    mem_opcode = s.mem_op; mem_rd = s.mem_rd;
    wb_opcode = s.wb_op;   wb_rd = s.wb_rd;
    branch_taken = s.taken; dmem_busy = s.busy;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(st(OP_NOP, 0, 0, OP_NOP, 0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(st(OP_R, 1, 2, OP_JAL, 0, 0, 1, OP_NOP, 0, OP_NOP, 0, 1, 0));
    #3;
    checks++;
    if (obs_a() !== 11'd0 || obs_b() !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctl: got %b/%b want 0", obs_a(), obs_b());
    end
    checks++;
    if ({stall_a, flush_a, stall_b, flush_b} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0", stall_a, flush_a, stall_b, flush_b);
    end
    do_reset();
  endtask

  task automatic test_forward();
    stim_t s[8];
    exp_t  x[8];
    exp_t  e;
    do_reset();
    s[0] = st(OP_R,   5, 6, OP_I,  1, 0, 5, OP_NOP, 0, OP_NOP, 0, 0, 0); x[0] = ex(pack(0,0,0,0,0,0,0,0), 0, 0);
    s[1] = st(OP_NOP, 0, 0, OP_R,  5, 6, 8, OP_I,   5, OP_NOP, 0, 0, 0); x[1] = ex(pack(0,0,0,0,0,0,1,0), 0, 0);
    s[2] = st(OP_NOP, 0, 0, OP_R,  5, 6, 8, OP_NOP, 0, OP_I,   5, 0, 0); x[2] = ex(pack(0,0,0,0,0,0,2,0), 0, 0);
    s[3] = st(OP_NOP, 0, 0, OP_R,  4, 4, 8, OP_I,   4, OP_LD,  4, 0, 0); x[3] = ex(pack(0,0,0,0,0,0,1,1), 0, 0);
    s[4] = st(OP_NOP, 0, 0, OP_R,  0, 0, 8, OP_I,   0, OP_I,   0, 0, 0); x[4] = ex(pack(0,0,0,0,0,0,0,0), 0, 0);
    s[5] = st(OP_NOP, 0, 0, OP_ST, 2, 9, 0, OP_LUI, 2, OP_LD,  9, 0, 0); x[5] = ex(pack(0,0,0,0,0,0,1,2), 0, 0);
    s[6] = st(OP_NOP, 0, 0, OP_LUI,3, 3, 8, OP_I,   3, OP_I,   3, 0, 0); x[6] = ex(pack(0,0,0,0,0,0,0,0), 0, 0);
    s[7] = st(OP_NOP, 0, 0, OP_R,  6, 6, 8, OP_ST,  6, OP_BR,  6, 0, 0); x[7] = ex(pack(0,0,0,0,0,0,0,0), 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e.ctl || {stall_a, flush_a} !== {e.stall, e.flush}) begin
        errors++;
        $display("FAIL forward[%0d]: got ctl=%b cnt=%0d/%0d want ctl=%b cnt=%0d/%0d",
                 i, obs_a(), stall_a, flush_a, e.ctl, e.stall, e.flush);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[5];
    exp_t  x[5];
    exp_t  e;
    do_reset();
    s[0] = st(OP_R,   1, 7, OP_LD,  2, 0, 7, OP_NOP, 0, OP_NOP, 0, 0, 0); x[0] = ex(pack(0,1,1,0,1,0,0,0), 0, 0);
    s[1] = st(OP_R,   1, 7, OP_NOP, 0, 0, 0, OP_LD,  7, OP_NOP, 0, 0, 0); x[1] = ex(pack(0,0,0,0,0,0,0,0), 1, 0);
    s[2] = st(OP_ST,  1, 4, OP_LD,  0, 0, 4, OP_NOP, 0, OP_NOP, 0, 0, 0); x[2] = ex(pack(0,1,1,0,1,0,0,0), 1, 0);
    s[3] = st(OP_R,   0, 0, OP_LD,  0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0); x[3] = ex(pack(0,0,0,0,0,0,0,0), 2, 0);
    s[4] = st(OP_LUI, 3, 3, OP_LD,  0, 0, 3, OP_NOP, 0, OP_NOP, 0, 0, 0); x[4] = ex(pack(0,0,0,0,0,0,0,0), 2, 0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e.ctl || {stall_a, flush_a} !== {e.stall, e.flush}) begin
        errors++;
        $display("FAIL load_use[%0d]: got ctl=%b cnt=%0d/%0d want ctl=%b cnt=%0d/%0d",
                 i, obs_a(), stall_a, flush_a, e.ctl, e.stall, e.flush);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[5];
    exp_t  x[5];
    exp_t  e;
    do_reset();
    s[0] = st(OP_NOP, 0, 0, OP_BR,   0, 0, 0, OP_NOP, 0, OP_NOP, 0, 1, 0); x[0] = ex(pack(3,0,0,1,1,0,0,0), 0, 0);
    s[1] = st(OP_NOP, 0, 0, OP_BR,   0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0); x[1] = ex(pack(0,0,0,0,0,0,0,0), 0, 1);
    s[2] = st(OP_NOP, 0, 0, OP_JAL,  0, 0, 1, OP_NOP, 0, OP_NOP, 0, 0, 0); x[2] = ex(pack(1,0,0,1,1,0,0,0), 0, 1);
    s[3] = st(OP_NOP, 0, 0, OP_JALR, 0, 0, 1, OP_NOP, 0, OP_NOP, 0, 0, 0); x[3] = ex(pack(2,0,0,1,1,0,0,0), 0, 2);
    s[4] = st(OP_NOP, 0, 0, OP_NOP,  0, 0, 0, OP_NOP, 0, OP_NOP, 0, 1, 0); x[4] = ex(pack(0,0,0,0,0,0,0,0), 0, 3);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e.ctl || {stall_a, flush_a} !== {e.stall, e.flush}) begin
        errors++;
        $display("FAIL redirect[%0d]: got ctl=%b cnt=%0d/%0d want ctl=%b cnt=%0d/%0d",
                 i, obs_a(), stall_a, flush_a, e.ctl, e.stall, e.flush);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[8];
    exp_t  x[8];
    exp_t  e;
    do_reset();
    s[0] = st(OP_NOP, 0, 0, OP_JALR, 0, 0, 1, OP_NOP, 0, OP_NOP, 0, 0, 1); x[0] = ex(pack(0,1,1,0,0,1,0,0), 0, 0);
    s[1] = st(OP_NOP, 0, 0, OP_JALR, 0, 0, 1, OP_NOP, 0, OP_NOP, 0, 0, 1); x[1] = ex(pack(0,1,1,0,0,1,0,0), 1, 0);
    s[2] = st(OP_NOP, 0, 0, OP_BR,   0, 0, 0, OP_NOP, 0, OP_NOP, 0, 1, 1); x[2] = ex(pack(0,1,1,0,0,1,0,0), 2, 0);
    s[3] = st(OP_NOP, 0, 0, OP_JALR, 0, 0, 1, OP_NOP, 0, OP_NOP, 0, 0, 0); x[3] = ex(pack(2,0,0,1,1,0,0,0), 3, 0);
    s[4] = st(OP_NOP, 0, 0, OP_NOP,  0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0); x[4] = ex(pack(0,0,0,0,0,0,0,0), 3, 1);
    s[5] = st(OP_R,   1, 7, OP_LD,   0, 0, 7, OP_NOP, 0, OP_NOP, 0, 0, 1); x[5] = ex(pack(0,1,1,0,0,1,0,0), 3, 1);
    s[6] = st(OP_R,   1, 7, OP_LD,   0, 0, 7, OP_NOP, 0, OP_NOP, 0, 0, 0); x[6] = ex(pack(0,1,1,0,1,0,0,0), 4, 1);
    s[7] = st(OP_NOP, 0, 0, OP_NOP,  0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0); x[7] = ex(pack(0,0,0,0,0,0,0,0), 5, 1);
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e.ctl || {stall_a, flush_a} !== {e.stall, e.flush}) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got ctl=%b cnt=%0d/%0d want ctl=%b cnt=%0d/%0d",
                 i, obs_a(), stall_a, flush_a, e.ctl, e.stall, e.flush);
      end
    end
  endtask

  // Stall-only instance checked against ctl, forwarding instance against ctl_alt.
  task automatic test_no_fwd();
    stim_t s[5];
    exp_t  x[5];
    exp_t  e;
    do_reset();
    s[0] = st(OP_R,   3, 1, OP_NOP, 0, 0, 0, OP_I,   3, OP_NOP, 0, 0, 0); x[0] = ex(pack(0,1,1,0,1,0,0,0), 0, 0);
    s[1] = st(OP_R,   3, 1, OP_NOP, 0, 0, 0, OP_NOP, 0, OP_I,   3, 0, 0); x[1] = ex(pack(0,1,1,0,1,0,0,0), 1, 0);
    s[2] = st(OP_R,   3, 1, OP_NOP, 0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0); x[2] = ex(pack(0,0,0,0,0,0,0,0), 2, 0);
    s[3] = st(OP_R,   2, 1, OP_R,   3, 0, 1, OP_I,   3, OP_NOP, 0, 0, 0);
    x[3] = ex(pack(0,1,1,0,1,0,0,0), 2, 0, pack(0,0,0,0,0,0,1,0));
    s[4] = st(OP_NOP, 0, 0, OP_NOP, 0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0); x[4] = ex(pack(0,0,0,0,0,0,0,0), 3, 0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_b() !== e.ctl || {stall_b, flush_b} !== {e.stall, e.flush} || obs_a() !== e.ctl_alt) begin
        errors++;
        $display("FAIL no_fwd[%0d]: got ctl=%b cnt=%0d/%0d fwd_inst=%b want ctl=%b cnt=%0d/%0d fwd_inst=%b",
                 i, obs_b(), stall_b, flush_b, obs_a(), e.ctl, e.stall, e.flush, e.ctl_alt);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t s[4];
    exp_t  x[4];
    exp_t  e;
    do_reset();
    s[0] = st(OP_NOP, 0, 0, OP_JAL, 0, 0, 1, OP_NOP, 0, OP_NOP, 0, 0, 1); x[0] = ex(pack(0,1,1,0,0,1,0,0), 0, 0);
    s[1] = st(OP_NOP, 0, 0, OP_JAL, 0, 0, 1, OP_NOP, 0, OP_NOP, 0, 0, 1); x[1] = ex(pack(0,1,1,0,0,1,0,0), 1, 0);
    s[2] = st(OP_NOP, 0, 0, OP_NOP, 0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 1); x[2] = ex(pack(0,1,1,0,0,1,0,0), 0, 0);
    s[3] = st(OP_NOP, 0, 0, OP_NOP, 0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0); x[3] = ex(pack(0,0,0,0,0,0,0,0), 1, 0);
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e.ctl || {stall_a, flush_a} !== {e.stall, e.flush}) begin
        errors++;
        $display("FAIL mid_wait[%0d]: got ctl=%b cnt=%0d/%0d want ctl=%b cnt=%0d/%0d",
                 i, obs_a(), stall_a, flush_a, e.ctl, e.stall, e.flush);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_a() !== 11'd0 || {stall_a, flush_a} !== '0) begin
      errors++;
      $display("FAIL async_reset: got ctl=%b cnt=%0d/%0d want all 0", obs_a(), stall_a, flush_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(st(OP_NOP, 0, 0, OP_NOP, 0, 0, 0, OP_NOP, 0, OP_NOP, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (obs_a() !== 11'd0 || {stall_a, flush_a} !== '0) begin
      errors++;
      $display("FAIL post_reset: got ctl=%b cnt=%0d/%0d want all 0", obs_a(), stall_a, flush_a);
    end
    for (int i = 2; i < 4; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_a() !== e.ctl || {stall_a, flush_a} !== {e.stall, e.flush}) begin
        errors++;
        $display("FAIL stale_pend[%0d]: got ctl=%b cnt=%0d/%0d want ctl=%b cnt=%0d/%0d",
                 i, obs_a(), stall_a, flush_a, e.ctl, e.stall, e.flush);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_back_to_back();
    test_mem_wait();
    test_no_fwd();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
